// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory-access stage with a multi-cycle word-addressed
// data memory, branch resolution, and the MEM/WB pipeline register.
// Optional feature: define MISALIGN_TRAP_EN to suppress accesses whose byte
// address is not word aligned and to raise a sticky Misaligned_out flag.
module mem_wb_stage #(
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        Branch_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [31:0] Add_Result_in,
   input  logic [31:0] ALU_Result_in,
   input  logic [31:0] Read_Data_2_in,
   input  logic [4:0]  Write_Addr_in,
   input  logic        Zero_in,
   output logic        PCSrc_out,
   output logic [31:0] Branch_Target_out,
   output logic        Mem_Stall_out,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic [31:0] Read_Data_out,
   output logic [31:0] ALU_Result_out,
   output logic [4:0]  Write_Addr_out
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        Misaligned_out
`endif
);

   localparam int         DEPTH  = 1 << ADDR_W;
   localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              access;
   logic              stall;
   logic              complete;
   logic              unused_addr_bits;

   // Byte address bits outside the word index do not select memory.
   assign idx              = ALU_Result_in[ADDR_W+1:2];
   assign unused_addr_bits = ^{ALU_Result_in[31:ADDR_W+2], ALU_Result_in[1:0]};

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (MemRead_in | MemWrite_in) & (ALU_Result_in[1:0] != 2'b00);
   assign access     = (MemRead_in | MemWrite_in) & ~misaligned;
`else
   assign access     = MemRead_in | MemWrite_in;
`endif

   // Stall is forced low while reset is held so upstream unfreezes at once.
   assign Mem_Stall_out     = stall & ~rst;
   assign PCSrc_out         = Branch_in & Zero_in & ~Mem_Stall_out;
   assign Branch_Target_out = Add_Result_in;

   // Access sequencer: decide stall, completion and the next state/count.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (MEM_LATENCY == 0) begin
                  complete = 1'b1;
               end else begin
                  stall      = 1'b1;
                  cnt_next   = LAT_M1;
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               stall    = 1'b1;
               cnt_next = cnt - 4'd1;
            end else begin
               complete   = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   // Sequencer state and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Store commits only in its completion cycle; reset discards it.
   always_ff @(posedge clk) begin
      if (!rst && complete && MemWrite_in) begin
         mem[idx] <= Read_Data_2_in;
      end
   end

   // MEM/WB register: capture when not stalled, otherwise insert a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite_out   <= 1'b0;
         MemtoReg_out   <= 1'b0;
         Read_Data_out  <= 32'd0;
         ALU_Result_out <= 32'd0;
         Write_Addr_out <= 5'd0;
      end else if (Mem_Stall_out) begin
         RegWrite_out <= 1'b0;
         MemtoReg_out <= 1'b0;
      end else begin
`ifdef MISALIGN_TRAP_EN
         RegWrite_out <= RegWrite_in & ~misaligned;
`else
         RegWrite_out <= RegWrite_in;
`endif
         MemtoReg_out   <= MemtoReg_in;
         Read_Data_out  <= mem[idx];
         ALU_Result_out <= ALU_Result_in;
         Write_Addr_out <= Write_Addr_in;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Sticky trap flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         Misaligned_out <= 1'b0;
      end else if (misaligned) begin
         Misaligned_out <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. One instance uses a
// two-cycle memory, a second uses single-cycle memory on the same inputs.
module tb_mem_wb_stage;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Zero_in;
   logic [31:0] Add_Result_in, ALU_Result_in, Read_Data_2_in;
   logic [4:0]  Write_Addr_in;

   logic        PCSrc_out, Mem_Stall_out, RegWrite_out, MemtoReg_out;
   logic [31:0] Branch_Target_out, Read_Data_out, ALU_Result_out;
   logic [4:0]  Write_Addr_out;

   logic        PCSrc_l0, Stall_l0, RegWrite_l0, MemtoReg_l0;
   logic [31:0] Target_l0, Read_Data_l0, ALU_Result_l0;
   logic [4:0]  Write_Addr_l0;
`ifdef MISALIGN_TRAP_EN
   logic        Misaligned_out, Misaligned_l0;
`endif

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [31:0] data;
      logic [31:0] alu;
      logic [4:0]  wa;
      int          stalls;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] model_mem [256];
   int          n_cmp;
   int          n_err;
   int          seen_stalls;
   int          seen_bubble_bad;
   bit          timed_out;

   mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .Add_Result_in(Add_Result_in), .ALU_Result_in(ALU_Result_in),
      .Read_Data_2_in(Read_Data_2_in), .Write_Addr_in(Write_Addr_in), .Zero_in(Zero_in),
      .PCSrc_out(PCSrc_out), .Branch_Target_out(Branch_Target_out),
      .Mem_Stall_out(Mem_Stall_out), .RegWrite_out(RegWrite_out),
      .MemtoReg_out(MemtoReg_out), .Read_Data_out(Read_Data_out),
      .ALU_Result_out(ALU_Result_out), .Write_Addr_out(Write_Addr_out)
`ifdef MISALIGN_TRAP_EN
      , .Misaligned_out(Misaligned_out)
`endif
   );

   mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .Add_Result_in(Add_Result_in), .ALU_Result_in(ALU_Result_in),
      .Read_Data_2_in(Read_Data_2_in), .Write_Addr_in(Write_Addr_in), .Zero_in(Zero_in),
      .PCSrc_out(PCSrc_l0), .Branch_Target_out(Target_l0),
      .Mem_Stall_out(Stall_l0), .RegWrite_out(RegWrite_l0),
      .MemtoReg_out(MemtoReg_l0), .Read_Data_out(Read_Data_l0),
      .ALU_Result_out(ALU_Result_l0), .Write_Addr_out(Write_Addr_l0)
`ifdef MISALIGN_TRAP_EN
      , .Misaligned_out(Misaligned_l0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one instruction at a negedge, push its expected MEM/WB contents,
   // and run until it leaves the stage, counting stall cycles and bubbles.
   task automatic issue_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] wa);
      exp_t       x;
      logic [7:0] i;
      logic       st;
      i        = addr[9:2];
      x.rw     = rw;
      x.m2r    = m2r;
      x.data   = model_mem[i];
      x.alu    = addr;
      x.wa     = wa;
      x.stalls = (rd | wr) ? LAT : 0;
      sb.push_back(x);
      if (wr) model_mem[i] = wdata;
      @(negedge clk);
      MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemtoReg_in = m2r;
      ALU_Result_in = addr; Read_Data_2_in = wdata; Write_Addr_in = wa;
      Branch_in = 1'b0; Zero_in = 1'b0; Add_Result_in = 32'd0;
      seen_stalls = 0; seen_bubble_bad = 0; timed_out = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         st = Mem_Stall_out;
         @(posedge clk);
         #1;
         if (!st) begin
            timed_out = 1'b0;
            break;
         end
         seen_stalls++;
         if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0) seen_bubble_bad++;
         @(negedge clk);
      end
   endtask

   task automatic clear_inputs();
      MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
      Branch_in = 0; Zero_in = 0; Add_Result_in = 0; ALU_Result_in = 0;
      Read_Data_2_in = 0; Write_Addr_in = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({RegWrite_out, MemtoReg_out, Read_Data_out, ALU_Result_out, Write_Addr_out} !== 71'd0) begin
         n_err++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {RegWrite_out, MemtoReg_out, Read_Data_out, ALU_Result_out, Write_Addr_out});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (Mem_Stall_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL reset_stall: got %b expected 0", Mem_Stall_out);
      end
   endtask

   task automatic test_store_load();
      issue_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
      e = sb.pop_front();
      n_cmp++;
      if (timed_out || seen_stalls != e.stalls) begin
         n_err++; $display("[TB] FAIL sw_stall_len: got %0d expected %0d", seen_stalls, e.stalls);
      end
      issue_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5);
      e = sb.pop_front();
      n_cmp++;
      if (timed_out || seen_stalls != e.stalls) begin
         n_err++; $display("[TB] FAIL lw_stall_len: got %0d expected %0d", seen_stalls, e.stalls);
      end
      n_cmp++;
      if (seen_bubble_bad != 0) begin
         n_err++; $display("[TB] FAIL lw_bubbles: got %0d non-bubble cycles expected 0", seen_bubble_bad);
      end
      n_cmp++;
      if (Read_Data_out !== e.data || e.data !== 32'hDEADBEEF) begin
         n_err++; $display("[TB] FAIL lw_data: got %h expected %h", Read_Data_out, e.data);
      end
      n_cmp++;
      if ({RegWrite_out, MemtoReg_out, Write_Addr_out} !== {e.rw, e.m2r, e.wa}) begin
         n_err++; $display("[TB] FAIL lw_ctrl: got %b%b/%0d expected %b%b/%0d",
                           RegWrite_out, MemtoReg_out, Write_Addr_out, e.rw, e.m2r, e.wa);
      end
      n_cmp++;
      if (ALU_Result_out !== e.alu) begin
         n_err++; $display("[TB] FAIL lw_alu: got %h expected %h", ALU_Result_out, e.alu);
      end
   endtask

   task automatic test_wrap();
      issue_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h55, 5'd0);
      e = sb.pop_front();
      issue_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd7);
      e = sb.pop_front();
      n_cmp++;
      if (Read_Data_out !== e.data) begin
         n_err++; $display("[TB] FAIL wrap_data: got %h expected %h", Read_Data_out, e.data);
      end
      issue_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd9);
      e = sb.pop_front();
      n_cmp++;
      if (timed_out || seen_stalls != e.stalls) begin
         n_err++; $display("[TB] FAIL alu_op_latency: got %0d stalls expected %0d", seen_stalls, e.stalls);
      end
      n_cmp++;
      if ({RegWrite_out, ALU_Result_out, Write_Addr_out} !== {e.rw, e.alu, e.wa}) begin
         n_err++; $display("[TB] FAIL alu_op_fields: got %b/%h/%0d expected %b/%h/%0d",
                           RegWrite_out, ALU_Result_out, Write_Addr_out, e.rw, e.alu, e.wa);
      end
   endtask

   task automatic test_both_set();
      issue_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 5'd0);
      e = sb.pop_front();
      issue_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 5'd3);
      e = sb.pop_front();
      n_cmp++;
      if (Read_Data_out !== e.data) begin
         n_err++; $display("[TB] FAIL rw_prewrite: got %h expected %h", Read_Data_out, e.data);
      end
      issue_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd4);
      e = sb.pop_front();
      n_cmp++;
      if (Read_Data_out !== e.data) begin
         n_err++; $display("[TB] FAIL rw_postwrite: got %h expected %h", Read_Data_out, e.data);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr_t [4] = '{32'h30, 32'h30, 32'h77, 32'h10};
      logic [31:0] wd_t   [4] = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
      logic        rd_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        wr_t   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         issue_op(rd_t[i], wr_t[i], ~wr_t[i], rd_t[i], addr_t[i], wd_t[i], 5'(i + 10));
         e = sb.pop_front();
         n_cmp++;
         if (timed_out || seen_stalls != e.stalls) begin
            n_err++; $display("[TB] FAIL b2b_stalls[%0d]: got %0d expected %0d", i, seen_stalls, e.stalls);
         end
         n_cmp++;
         if ({RegWrite_out, MemtoReg_out, Write_Addr_out, ALU_Result_out} !== {e.rw, e.m2r, e.wa, e.alu}) begin
            n_err++; $display("[TB] FAIL b2b_fields[%0d]: got %b%b/%0d/%h expected %b%b/%0d/%h", i,
                              RegWrite_out, MemtoReg_out, Write_Addr_out, ALU_Result_out,
                              e.rw, e.m2r, e.wa, e.alu);
         end
         if (rd_t[i]) begin
            n_cmp++;
            if (Read_Data_out !== e.data) begin
               n_err++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, Read_Data_out, e.data);
            end
         end
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      clear_inputs();
      Branch_in = 1'b1; Zero_in = 1'b1; Add_Result_in = 32'h40;
      #1;
      n_cmp++;
      if (PCSrc_out !== 1'b1 || Branch_Target_out !== 32'h40) begin
         n_err++; $display("[TB] FAIL branch_taken: got %b/%h expected 1/00000040", PCSrc_out, Branch_Target_out);
      end
      Zero_in = 1'b0;
      #1;
      n_cmp++;
      if (PCSrc_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL branch_not_zero: got %b expected 0", PCSrc_out);
      end
      Zero_in = 1'b1; MemRead_in = 1'b1; ALU_Result_in = 32'h10;
      #1;
      n_cmp++;
      if (PCSrc_out !== 1'b0 || Mem_Stall_out !== 1'b1) begin
         n_err++; $display("[TB] FAIL branch_in_stall: got pcsrc=%b stall=%b expected 0/1", PCSrc_out, Mem_Stall_out);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (PCSrc_out !== 1'b1 || Mem_Stall_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL branch_at_completion: got pcsrc=%b stall=%b expected 1/0", PCSrc_out, Mem_Stall_out);
      end
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_access();
      issue_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0000_AAAA, 5'd0);
      e = sb.pop_front();
      @(negedge clk);
      MemWrite_in = 1'b1; ALU_Result_in = 32'h8; Read_Data_2_in = 32'h1234;
      RegWrite_in = 1'b0; MemtoReg_in = 1'b0; MemRead_in = 1'b0;
      #1;
      n_cmp++;
      if (Mem_Stall_out !== 1'b1) begin
         n_err++; $display("[TB] FAIL abort_stall_start: got %b expected 1", Mem_Stall_out);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (Mem_Stall_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL abort_stall_in_reset: got %b expected 0", Mem_Stall_out);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({RegWrite_out, MemtoReg_out, Read_Data_out, ALU_Result_out, Write_Addr_out} !== 71'd0) begin
         n_err++; $display("[TB] FAIL abort_outputs: got %h expected 0",
                           {RegWrite_out, MemtoReg_out, Read_Data_out, ALU_Result_out, Write_Addr_out});
      end
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      #1;
      n_cmp++;
      if (Mem_Stall_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL abort_stall_after: got %b expected 0", Mem_Stall_out);
      end
      issue_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 5'd2);
      e = sb.pop_front();
      n_cmp++;
      if (Read_Data_out !== e.data) begin
         n_err++; $display("[TB] FAIL abort_mem_unchanged: got %h expected %h", Read_Data_out, e.data);
      end
   endtask

   // Single-cycle instance: one load per cycle. Address 0x8 is skipped since
   // the aborted store above did commit in this zero-latency instance.
   task automatic test_latency0();
      logic [31:0] addr_t [5] = '{32'h10, 32'h0, 32'h30, 32'h20, 32'h10};
      exp_t        x;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clear_inputs();
         MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
         ALU_Result_in = addr_t[i]; Write_Addr_in = 5'(i + 20);
         x.rw = 1'b1; x.m2r = 1'b1; x.data = model_mem[addr_t[i][9:2]];
         x.alu = addr_t[i]; x.wa = 5'(i + 20); x.stalls = 0;
         sb.push_back(x);
         #1;
         n_cmp++;
         if (Stall_l0 !== 1'b0) begin
            n_err++; $display("[TB] FAIL lat0_stall[%0d]: got %b expected 0", i, Stall_l0);
         end
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (Read_Data_l0 !== e.data || Write_Addr_l0 !== e.wa || RegWrite_l0 !== e.rw) begin
            n_err++; $display("[TB] FAIL lat0_load[%0d]: got %h/%0d/%b expected %h/%0d/%b", i,
                              Read_Data_l0, Write_Addr_l0, RegWrite_l0, e.data, e.wa, e.rw);
         end
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef MISALIGN_TRAP_EN
   task automatic test_misaligned();
      @(negedge clk);
      clear_inputs();
      MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1; ALU_Result_in = 32'h2;
      #1;
      n_cmp++;
      if (Mem_Stall_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL mis_stall: got %b expected 0", Mem_Stall_out);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (RegWrite_out !== 1'b0 || Misaligned_out !== 1'b1) begin
         n_err++; $display("[TB] FAIL mis_capture: got rw=%b flag=%b expected 0/1", RegWrite_out, Misaligned_out);
      end
      @(negedge clk);
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (Misaligned_out !== 1'b1) begin
         n_err++; $display("[TB] FAIL mis_sticky: got %b expected 1", Misaligned_out);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (Misaligned_out !== 1'b0) begin
         n_err++; $display("[TB] FAIL mis_clear: got %b expected 0", Misaligned_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask
`endif

   // Test sequence.
   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
      test_reset();
      test_store_load();
      test_wrap();
      test_both_set();
      test_back_to_back();
      test_branch();
      test_reset_mid_access();
      test_latency0();
`ifdef MISALIGN_TRAP_EN
      test_misaligned();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
